// File: rtl/game_pkg.sv
// Shared game definitions: game-state codes used by the judge, score counter and
// top-level FSM, plus the judge's own state encoding and default window length.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SONG_SELECT = 2'd1,
    GAME_PLAY   = 2'd2,
    GAME_OVER   = 2'd3
  } game_state_e;

  typedef enum logic {
    J_IDLE = 1'b0,
    J_OPEN = 1'b1
  } judge_state_e;

  localparam int         WINDOW_DEFAULT = 24;
  localparam logic [7:0] COMBO_MAX      = 8'd255;

endpackage

// File: rtl/hit_judge_if.sv
// Bundle of chart/button inputs and judgment outputs around the hit judge.
// master = chart sequencer / button side, slave = the judge itself.
interface hit_judge_if;

  logic [1:0] current_state;
  logic       tick;
  logic [1:0] note;
  logic [1:0] btn;
  logic [1:0] Inp;
  logic [7:0] combo;
  logic [7:0] max_combo;
  logic       judge_valid;

  modport master (
    output current_state, tick, note, btn,
    input  Inp, combo, max_combo, judge_valid
  );

  modport slave (
    input  current_state, tick, note, btn,
    output Inp, combo, max_combo, judge_valid
  );

endinterface

// File: rtl/btn_edge.sv
// Two-flop synchronizer for asynchronous buttons followed by a rising-edge
// detector, so a held button yields a single one-cycle press.
module btn_edge #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] btn,
    output logic [W-1:0] press
);

    logic [W-1:0] sync1_q, sync1_d;
    logic [W-1:0] sync2_q, sync2_d;
    logic [W-1:0] prev_q,  prev_d;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign press = sync2_q & ~prev_q;

endmodule

// File: rtl/hit_judge.sv
// Judges 2-lane button presses against chart notes inside a WINDOW-cycle window
// after each tick, and maintains the running and maximum combo.
module hit_judge
  import game_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEFAULT,
    parameter int CNT_W  = 8
) (
    input  logic        clk,
    input  logic        rst,
    hit_judge_if.slave  bus
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == COMBO_MAX) ? COMBO_MAX : v + 8'd1;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    judge_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0] note_q, note_d;
    logic [1:0] hit_q, hit_d;
    logic [1:0] inp_q, inp_d;
    logic       jv_q, jv_d;
    logic [7:0] combo_q, combo_d;
    logic [7:0] max_q, max_d;

    logic [1:0] press;
    logic [1:0] hit_next;
    logic [7:0] combo_new;
    logic       play;
    logic       window_end;

    btn_edge #(.W(2)) u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn),
        .press (press)
    );

    assign play       = (bus.current_state == GAME_PLAY);
    assign window_end = (cnt_q == CNT_W'(WINDOW - 1));
    // Presses on lanes without a note never set a hit flag.
    assign hit_next   = hit_q | (press & note_q);

    always_comb begin
        combo_new = combo_q;
        if (note_q != 2'b00) begin
            if ((hit_next & note_q) == note_q) combo_new = sat_inc(combo_q);
            else                               combo_new = 8'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        note_d  = note_q;
        hit_d   = hit_q;
        inp_d   = 2'b00;
        jv_d    = 1'b0;
        combo_d = combo_q;
        max_d   = max_q;

        if (!play) begin
            // Any open window is dropped unjudged; it must not leak into the next song.
            state_d = J_IDLE;
            cnt_d   = '0;
            note_d  = 2'b00;
            hit_d   = 2'b00;
            if (bus.current_state == SONG_SELECT) begin
                combo_d = 8'd0;
                max_d   = 8'd0;
            end
        end else begin
            case (state_q)
                J_IDLE: begin
                    if (bus.tick) begin
                        note_d  = bus.note;
                        hit_d   = 2'b00;
                        cnt_d   = '0;
                        state_d = J_OPEN;
                    end
                end
                J_OPEN: begin
                    hit_d = hit_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (bus.tick || window_end) begin
                        inp_d   = note_q & hit_next;
                        jv_d    = 1'b1;
                        combo_d = combo_new;
                        max_d   = max8(max_q, combo_new);
                        if (bus.tick) begin
                            // Back-to-back tick: the old window closes and a new one opens at once.
                            note_d  = bus.note;
                            hit_d   = 2'b00;
                            cnt_d   = '0;
                        end else begin
                            state_d = J_IDLE;
                        end
                    end
                end
                default: state_d = J_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= J_IDLE;
            cnt_q   <= '0;
            note_q  <= 2'b00;
            hit_q   <= 2'b00;
            inp_q   <= 2'b00;
            jv_q    <= 1'b0;
            combo_q <= 8'd0;
            max_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            note_q  <= note_d;
            hit_q   <= hit_d;
            inp_q   <= inp_d;
            jv_q    <= jv_d;
            combo_q <= combo_d;
            max_q   <= max_d;
        end
    end

    assign bus.Inp         = inp_q;
    assign bus.judge_valid = jv_q;
    assign bus.combo       = combo_q;
    assign bus.max_combo   = max_q;

endmodule
